dot_product_mac: RTL and testbench

Signed multiply-accumulate stage directly downstream of the matrix multiplier's register banks. Consumes one operand pair per accepted beat (one row element, one column element) over a valid/ready stream. Accumulates exactly `vec_len` products into a full-precision sum, then holds the dot-product result on a valid/ready output until taken. One instance produces one output-matrix element per start/result transaction.

---
 rtl/mm_pkg.sv | 16 +
 rtl/dot_product_mac_if.sv | 25 ++
 rtl/dot_product_mac.sv | 100 ++++++++++
 tb/tb_dot_product_mac.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: MAC controller states
// and the accumulator sizing rule reused by the writeback stage.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_e;

    // Full-precision width for vec_len signed products of data_width operands.
    function automatic int acc_w(input int data_width, input int vec_len);
        return 2 * data_width + $clog2(vec_len);
    endfunction

endpackage

// File: rtl/dot_product_mac_if.sv
// Operand stream, result stream and status bundle of the dot-product MAC.
interface dot_product_mac_if #(
    parameter int data_width = 8,
    parameter int acc_width  = mm_pkg::acc_w(8, 64)
);
    logic                  start;
    logic [data_width-1:0] a_in;
    logic [data_width-1:0] b_in;
    logic                  in_valid;
    logic                  in_ready;
    logic [acc_width-1:0]  result;
    logic                  result_valid;
    logic                  result_ready;
    logic                  busy;

    modport slave (
        input  start, a_in, b_in, in_valid, result_ready,
        output in_ready, result, result_valid, busy
    );

    modport master (
        output start, a_in, b_in, in_valid, result_ready,
        input  in_ready, result, result_valid, busy
    );
endinterface

// File: rtl/dot_product_mac.sv
// Signed multiply-accumulate over vec_len operand beats; the finished dot product
// is held on a valid/ready output until taken.
module dot_product_mac
    import mm_pkg::*;
#(
    parameter int data_width = 8,
    parameter int vec_len    = 64,
    parameter int acc_width  = acc_w(data_width, vec_len)
) (
    input  logic             clk,
    input  logic             reset,
    dot_product_mac_if.slave bus
);

    localparam int CNT_W  = $clog2(vec_len);
    localparam int PROD_W = 2 * data_width;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(vec_len - 1);

    mac_state_e                  state_q, state_d;
    logic signed [acc_width-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [acc_width-1:0]        result_q, result_d;

    logic signed [PROD_W-1:0]    prod_s;
    logic signed [acc_width-1:0] prod_ext_s;
    logic signed [acc_width-1:0] sum_s;
    logic                        accept_s;

    // Datapath: one signed multiply, sign-extend, one add.
    always_comb begin
        prod_s     = $signed(bus.a_in) * $signed(bus.b_in);
        prod_ext_s = {{(acc_width - PROD_W){prod_s[PROD_W-1]}}, prod_s};
        sum_s      = acc_q + prod_ext_s;
        accept_s   = (state_q == ACCUM) && bus.in_valid;
    end

    // Next-state and register-update logic for the IDLE/ACCUM/HOLD controller.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s) begin
                    acc_d = sum_s;
                    if (cnt_q == LAST_CNT) begin
                        // The last beat's product goes straight into the result.
                        result_d = sum_s;
                        state_d  = HOLD;
                    end else begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ACCUM;
                end
            end
            HOLD: begin
                if (bus.result_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, accumulator, beat counter and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready     = (state_q == ACCUM);
    assign bus.result_valid = (state_q == HOLD);
    assign bus.busy         = (state_q != IDLE);
    assign bus.result       = result_q;

endmodule

// File: tb/tb_dot_product_mac.sv
// Self-checking bench for dot_product_mac: table of directed transactions,
// random transactions against a sum-of-products model, and control corner cases.
module tb_dot_product_mac;

    localparam int DW  = 8;
    localparam int VL  = 64;
    localparam int ACW = 2 * DW + $clog2(VL);

    typedef struct {
        int a0;
        int a_step;
        int b;
        int stall_pct;
        int hold;
        int expected;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   a_vec[$];
    int   b_vec[$];

    dot_product_mac_if #(.data_width(DW), .acc_width(ACW)) bus();

    dot_product_mac #(.data_width(DW), .vec_len(VL), .acc_width(ACW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int res_val();
        return int'($signed(bus.result));
    endfunction

    function automatic int model_sum();
        int s = 0;
        foreach (a_vec[i]) s += a_vec[i] * b_vec[i];
        return s;
    endfunction

    task automatic do_start();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start->in_ready", int'(bus.in_ready), 1);
        check("start->busy", int'(bus.busy), 1);
    endtask

    // Presents a_vec/b_vec with random gaps; optionally toggles start while accumulating.
    task automatic send_beats(input int stall_pct, input bit start_noise);
        int i = 0;
        int guard = 0;
        bit take;
        while (i < a_vec.size() && guard < 4000) begin
            if (int'($urandom_range(99)) < stall_pct) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.a_in = DW'(a_vec[i]);
                bus.b_in = DW'(b_vec[i]);
            end
            bus.start = start_noise ? 1'($urandom_range(1)) : 1'b0;
            take = bus.in_valid && bus.in_ready;
            @(negedge clk);
            if (take) i++;
            guard++;
        end
        bus.in_valid = 1'b0;
        bus.start = 1'b0;
        if (i < a_vec.size()) check("beat timeout", i, a_vec.size());
    endtask

    // Checks the held result for `hold` stalled cycles, then hands it off.
    task automatic finish_txn(input string name, input int exp, input int hold, input bit start_at_handoff);
        check({name, " valid"}, int'(bus.result_valid), 1);
        check({name, " result"}, res_val(), exp);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            check({name, " hold result"}, res_val(), exp);
            check({name, " hold in_ready"}, int'(bus.in_ready), 0);
            check({name, " hold valid"}, int'(bus.result_valid), 1);
        end
        bus.result_ready = 1'b1;
        bus.start = start_at_handoff;
        @(negedge clk);
        bus.result_ready = 1'b0;
        bus.start = 1'b0;
        check({name, " valid drop"}, int'(bus.result_valid), 0);
        check({name, " busy drop"}, int'(bus.busy), 0);
        check({name, " idle in_ready"}, int'(bus.in_ready), 0);
        check({name, " result kept"}, res_val(), exp);
    endtask

    task automatic fill(input int a0, input int a_step, input int b, input int n);
        a_vec.delete();
        b_vec.delete();
        for (int i = 0; i < n; i++) begin
            a_vec.push_back(a0 + a_step * i);
            b_vec.push_back(b);
        end
    endtask

    initial begin
        vec_t tbl[6];
        tbl[0] = '{a0: 1,    a_step: 0, b: 1,    stall_pct: 0,  hold: 0,  expected: 64};
        tbl[1] = '{a0: -128, a_step: 0, b: -128, stall_pct: 0,  hold: 0,  expected: 1048576};
        tbl[2] = '{a0: -128, a_step: 0, b: 127,  stall_pct: 0,  hold: 0,  expected: -1040384};
        tbl[3] = '{a0: 0,    a_step: 1, b: 2,    stall_pct: 35, hold: 10, expected: 4032};
        tbl[4] = '{a0: 2,    a_step: 0, b: 3,    stall_pct: 10, hold: 2,  expected: 384};
        tbl[5] = '{a0: 127,  a_step: 0, b: -128, stall_pct: 0,  hold: 1,  expected: -1040384};

        bus.start = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.in_valid = 1'b0;
        bus.result_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("reset in_ready", int'(bus.in_ready), 0);
        check("reset valid", int'(bus.result_valid), 0);
        check("reset busy", int'(bus.busy), 0);
        check("reset result", res_val(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", int'(bus.busy), 0);

        // Beat presented together with start in IDLE must not be counted.
        bus.start = 1'b1;
        bus.in_valid = 1'b1;
        bus.a_in = 8'd5;
        bus.b_in = 8'd5;
        @(negedge clk);
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        fill(1, 0, 1, VL - 1);
        send_beats(0, 1'b0);
        check("63 beats still accum", int'(bus.in_ready), 1);
        check("63 beats no valid", int'(bus.result_valid), 0);
        fill(1, 0, 1, 1);
        send_beats(0, 1'b0);
        finish_txn("start-beat", 64, 0, 1'b1);

        // Reset in the middle of accumulation clears everything without a clock edge.
        do_start();
        fill(7, 0, 9, 30);
        send_beats(0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check("midreset in_ready", int'(bus.in_ready), 0);
        check("midreset busy", int'(bus.busy), 0);
        check("midreset valid", int'(bus.result_valid), 0);
        check("midreset result", res_val(), 0);
        @(negedge clk);
        reset = 1'b1;

        // Directed table; consecutive rows are separated by one IDLE cycle.
        foreach (tbl[k]) begin
            do_start();
            fill(tbl[k].a0, tbl[k].a_step, tbl[k].b, VL);
            send_beats(tbl[k].stall_pct, k == 3);
            finish_txn($sformatf("row%0d", k), tbl[k].expected, tbl[k].hold, k == 3);
        end

        // Random operands against the reference sum.
        for (int t = 0; t < 4; t++) begin
            int exp;
            a_vec.delete();
            b_vec.delete();
            for (int i = 0; i < VL; i++) begin
                a_vec.push_back(int'($urandom_range(255)) - 128);
                b_vec.push_back(int'($urandom_range(255)) - 128);
            end
            exp = model_sum();
            do_start();
            send_beats(20, 1'b1);
            finish_txn($sformatf("rand%0d", t), exp, int'($urandom_range(3)), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
